icache_mem_responder: RTL
=========================

# icache_mem_responder

Memory-side responder for the instruction cache's miss interface. It accepts block-fill requests on the cache's memory request port and returns the addressed 16-word block as eight 40-bit beats after a configurable access latency. Storage is an internal word array, preloaded through a side port. It serves as the backing memory model in the instruction-cache subsystem and as the stand-in for the external memory controller.

## Interface
Parameters:
- ADDR_WIDTH, 16, word address width; matches the cache request address.
- WORD_WIDTH, 20, instruction word width.
- MEM_IF_DATA_WIDTH, 40, beat width; always 2 words.
- MEM_DEPTH_WORDS, 4096, array depth; power of two, multiple of 16.
- READ_LATENCY, 4, wait cycles between request acceptance and the first beat; 0 is legal.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- arst_n  in  1  asynchronous active-low reset.
- i_halt  in  1  freezes all state; outputs hold their values.
- i_mem_addr  in  ADDR_WIDTH  requested word address; bits [3:0] give the critical word.
- i_mem_req_valid  in  1  request valid.
- o_req_ready  out  1  request accepted when valid & ready.
- o_mem_data  out  40  beat data: [19:0] even word, [39:20] odd word.
- o_mem_data_valid  out  1  beat valid.
- i_mem_if_ready  in  1  cache can take the beat; a beat transfers on valid & ready.
- i_ld_addr  in  ADDR_WIDTH  preload word address.
- i_ld_data  in  WORD_WIDTH  preload data.
- i_ld_valid  in  1  preload write strobe.

## Operation
- FSM states:
  - IDLE: o_req_ready=1 when i_halt=0. On valid & ready, latch the block base (addr & ~0xF) and go to WAIT, or to BURST if READ_LATENCY=0.
  - WAIT: latency counter counts down from READ_LATENCY-1. At 0, load beat 0 into the output register and go to BURST.
  - BURST: o_mem_data_valid=1. On each beat handshake, the beat index increments and the next beat is registered. A handshake on the last beat (index 7) returns to IDLE.
- Beat k carries words base+2k (bits [19:0]) and base+2k+1 (bits [39:20]). The array index is the address modulo MEM_DEPTH_WORDS, so high addresses wrap silently.
- When i_mem_if_ready=0, the beat is held stable; data must not change while valid is high and ready is low.
- Requests arriving outside IDLE are not accepted (ready=0). The cache holds its request until it is accepted.
- Preload:
  - A preload write happens only in IDLE.
  - If i_ld_valid and an accepted request occur in the same cycle, the preload write happens first, so the burst returns the new word.
  - i_ld_valid is ignored outside IDLE.
- Array contents are not reset.

## Timing
- Reset values: o_req_ready=0 during reset and 1 from the first cycle after deassertion; o_mem_data=0; o_mem_data_valid=0; FSM=IDLE; counters=0.
- Request accepted at cycle T → first beat valid at T+1+READ_LATENCY. With a cache that is always ready, the last beat is at T+8+READ_LATENCY.
- Last beat handshake at cycle L → FSM in IDLE at L+1, with o_req_ready=1 at L+1. The minimum request-to-request spacing is 9+READ_LATENCY cycles.
- i_halt=1 freezes the state, counters and output register. Handshakes are not counted while halted.
- arst_n asserted mid-burst → immediate return to IDLE with valid=0. A partial burst is abandoned and not resumed.

## Configuration
- ICACHE_MEM_CRITICAL_BEAT_FIRST_EN:
  - Defined: the burst starts at beat addr[3:1] and wraps modulo 8. For example, addr[3:0]=0xB returns beats 5,6,7,0,1,2,3,4.
  - Undefined: beats are always returned in order 0..7.
- The macro must match the miss handler's fill-order expectation.

## Structure
- Shared package/include:
  - ADDR_WIDTH, WORD_WIDTH, MEM_IF_DATA_WIDTH.
  - BEATS_PER_BLOCK=8, WORDS_PER_BEAT=2.
  - Responder state encoding (IDLE/WAIT/BURST), shared with the miss handler bench.
- One sub-module, mem_word_array: MEM_DEPTH_WORDS×WORD_WIDTH with one write port (preload) and a two-word combinational read at an even index. The FSM, counters and output register live in the top.

## Test plan
- Preload words 0x00010..0x0001F with values equal to their addresses. Request addr 0x0013, READ_LATENCY=4, ready held at 1 → valid from T+5 to T+12. Beats are {0x00011,0x00010} .. {0x0001F,0x0001E}, in critical-beat order 1..7,0 when the macro is defined.
- Same request with i_mem_if_ready toggled 1,0,0,1 → each beat is held unchanged across the stall cycles. Exactly 8 handshakes occur, then ready returns to 1.
- Request addr 0xFFF0 with MEM_DEPTH_WORDS=4096 → data comes from array indices 0xFF0..0xFFF (wrap). o_req_ready=0 for the whole burst, and a second request asserted mid-burst is accepted only after the burst ends.
- Assert arst_n=0 at beat 3 → valid=0 immediately. After release, o_req_ready=1 and a new request returns the full 8 beats.
- i_halt=1 for 3 cycles during WAIT → first beat delayed by exactly 3 cycles.
- Preload write to 0x0020 and request 0x0020 in the same IDLE cycle → beat 0 low word equals the new data.

Source files
------------

// File: rtl/icache_mem_responder_pkg.sv
// Shared widths, block geometry and responder state encoding for the icache memory responder
// and the miss-handler bench that observes it.
package icache_mem_responder_pkg;

    localparam int ADDR_WIDTH        = 16;
    localparam int WORD_WIDTH        = 20;
    localparam int MEM_IF_DATA_WIDTH = 40;
    localparam int BEATS_PER_BLOCK   = 8;
    localparam int WORDS_PER_BEAT    = 2;
    localparam int BEAT_IDX_WIDTH    = $clog2(BEATS_PER_BLOCK);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_BURST = 2'd2
    } resp_state_t;

    // Beat number within the block for the count-th beat of a burst; wraps modulo the block.
    function automatic logic [BEAT_IDX_WIDTH-1:0] beat_sel(
        input logic [BEAT_IDX_WIDTH-1:0] start,
        input logic [BEAT_IDX_WIDTH-1:0] count
    );
        return start + count;
    endfunction

endpackage

// File: rtl/icache_mem_responder_mem_word_array.sv
// Word-wide backing store: one synchronous write port for preload and an unregistered
// read of an aligned even/odd word pair.
module mem_word_array #(
    parameter int DEPTH = 4096,
    parameter int WIDTH = 20,
    parameter int WORDS = 2,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic                        clk,
    input  logic                        wr_en,
    input  logic [IDX_W-1:0]            wr_idx,
    input  logic [WIDTH-1:0]            wr_data,
    input  logic [IDX_W-2:0]            rd_pair,
    output logic [WORDS-1:0][WIDTH-1:0] rd_words
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < WORDS; gi++) begin : g_rd
            assign rd_words[gi] = mem[{rd_pair, 1'(gi)}];
        end
    endgenerate

endmodule

// File: rtl/icache_mem_responder.sv
// Block-fill responder for the icache miss port: returns a 16-word block as eight 2-word beats.
// ICACHE_MEM_CRITICAL_BEAT_FIRST_EN starts the burst at the critical beat and wraps.
module icache_mem_responder #(
    parameter int ADDR_WIDTH        = icache_mem_responder_pkg::ADDR_WIDTH,
    parameter int WORD_WIDTH        = icache_mem_responder_pkg::WORD_WIDTH,
    parameter int MEM_IF_DATA_WIDTH = icache_mem_responder_pkg::MEM_IF_DATA_WIDTH,
    parameter int MEM_DEPTH_WORDS   = 4096,
    parameter int READ_LATENCY      = 4
) (
    input  logic                         clk,
    input  logic                         arst_n,
    input  logic                         i_halt,
    input  logic [ADDR_WIDTH-1:0]        i_mem_addr,
    input  logic                         i_mem_req_valid,
    output logic                         o_req_ready,
    output logic [MEM_IF_DATA_WIDTH-1:0] o_mem_data,
    output logic                         o_mem_data_valid,
    input  logic                         i_mem_if_ready,
    input  logic [ADDR_WIDTH-1:0]        i_ld_addr,
    input  logic [WORD_WIDTH-1:0]        i_ld_data,
    input  logic                         i_ld_valid
);
    import icache_mem_responder_pkg::*;

    localparam int IDX_W = $clog2(MEM_DEPTH_WORDS);
    localparam int BLK_W = IDX_W - 4;
    localparam int LAT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'((READ_LATENCY > 0) ? READ_LATENCY - 1 : 0);
    localparam logic [BEAT_IDX_WIDTH-1:0] LAST_BEAT = BEAT_IDX_WIDTH'(BEATS_PER_BLOCK - 1);

    resp_state_t                        state_reg, state_next;
    logic [BLK_W-1:0]                   blk_reg, blk_next;
    logic [BEAT_IDX_WIDTH-1:0]          start_reg, start_next;
    logic [BEAT_IDX_WIDTH-1:0]          cnt_reg, cnt_next;
    logic [LAT_W-1:0]                   lat_reg, lat_next;
    logic [MEM_IF_DATA_WIDTH-1:0]       data_reg, data_next;
    logic                               valid_reg, valid_next;
    logic                               rdy_en_reg;

    logic                               accept;
    logic                               ld_we;
    logic                               load_beat;
    logic [BLK_W-1:0]                   rd_blk;
    logic [BEAT_IDX_WIDTH-1:0]          rd_beat;
    logic [IDX_W-2:0]                   rd_pair;
    logic [BEAT_IDX_WIDTH-1:0]          req_start;
    logic [WORDS_PER_BEAT-1:0][WORD_WIDTH-1:0] arr_words;
    logic [WORDS_PER_BEAT-1:0][WORD_WIDTH-1:0] beat_words;

    assign o_req_ready      = rdy_en_reg && (state_reg == ST_IDLE) && !i_halt;
    assign o_mem_data       = data_reg;
    assign o_mem_data_valid = valid_reg;

    assign accept  = o_req_ready && i_mem_req_valid;
    assign ld_we   = i_ld_valid && o_req_ready;
    assign rd_pair = {rd_blk, rd_beat};

`ifdef ICACHE_MEM_CRITICAL_BEAT_FIRST_EN
    assign req_start = i_mem_addr[3:1];
`else
    assign req_start = '0;
`endif

    mem_word_array #(
        .DEPTH (MEM_DEPTH_WORDS),
        .WIDTH (WORD_WIDTH),
        .WORDS (WORDS_PER_BEAT)
    ) u_array (
        .clk      (clk),
        .wr_en    (ld_we),
        .wr_idx   (i_ld_addr[IDX_W-1:0]),
        .wr_data  (i_ld_data),
        .rd_pair  (rd_pair),
        .rd_words (arr_words)
    );

    // A preload landing in the accept cycle must be visible to a zero-latency beat 0.
    genvar gi;
    generate
        for (gi = 0; gi < WORDS_PER_BEAT; gi++) begin : g_fwd
            assign beat_words[gi] = (ld_we && (i_ld_addr[IDX_W-1:0] == {rd_pair, 1'(gi)}))
                                    ? i_ld_data : arr_words[gi];
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        blk_next   = blk_reg;
        start_next = start_reg;
        cnt_next   = cnt_reg;
        lat_next   = lat_reg;
        data_next  = data_reg;
        valid_next = valid_reg;
        load_beat  = 1'b0;
        rd_blk     = blk_reg;
        rd_beat    = beat_sel(start_reg, cnt_reg + 1'b1);

        if (!i_halt) begin
            unique case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        blk_next   = i_mem_addr[IDX_W-1:4];
                        start_next = req_start;
                        cnt_next   = '0;
                        lat_next   = LAT_INIT;
                        rd_blk     = i_mem_addr[IDX_W-1:4];
                        rd_beat    = req_start;
                        if (READ_LATENCY == 0) begin
                            load_beat  = 1'b1;
                            state_next = ST_BURST;
                        end else begin
                            state_next = ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (lat_reg == '0) begin
                        rd_beat    = start_reg;
                        load_beat  = 1'b1;
                        state_next = ST_BURST;
                    end else begin
                        lat_next = lat_reg - 1'b1;
                    end
                end
                ST_BURST: begin
                    if (i_mem_if_ready) begin
                        if (cnt_reg == LAST_BEAT) begin
                            state_next = ST_IDLE;
                            valid_next = 1'b0;
                            cnt_next   = '0;
                        end else begin
                            cnt_next  = cnt_reg + 1'b1;
                            load_beat = 1'b1;
                        end
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end

        if (load_beat) begin
            data_next  = beat_words;
            valid_next = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_reg  <= ST_IDLE;
            blk_reg    <= '0;
            start_reg  <= '0;
            cnt_reg    <= '0;
            lat_reg    <= '0;
            data_reg   <= '0;
            valid_reg  <= 1'b0;
            rdy_en_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            blk_reg    <= blk_next;
            start_reg  <= start_next;
            cnt_reg    <= cnt_next;
            lat_reg    <= lat_next;
            data_reg   <= data_next;
            valid_reg  <= valid_next;
            rdy_en_reg <= 1'b1;
        end
    end

endmodule
